// File: rtl/uart_wbm_burst.sv
// uart_wbm_burst: turns a UART byte stream into Wishbone burst transfers.
// Frame: CMD, AW/8 address bytes (MSB first), then LEN words of write data
// (writes only, each word MSB first). Read data and a final status byte
// (0x80 ok, 0x81 bus error, 0x82 timeout) are returned on the tx side.
// Optional feature: define UART_WBM_TIMEOUT_EN to bound the Wishbone wait
// to TIMEOUT_CYC cycles; without it the master waits forever for ack/err.
module uart_wbm_burst #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              rx_wr,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              tx_data_avail,
   output logic [7:0]        tx_data,
   input  logic              tx_rd,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic [AW-1:0]     wbm_adr_o,
   output logic              wbm_we_o,
   output logic [DW-1:0]     wbm_dat_o,
   output logic [DW/8-1:0]   wbm_sel_o,
   input  logic [DW-1:0]     wbm_dat_i,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i,
   output logic              busy,
   output logic              cmd_err
);

   localparam int NA  = AW / 8;
   localparam int NB  = DW / 8;
   localparam int DLW = $clog2(16 * NB + 1);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_BUS_ERR = 2'd1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      WB_REQ,
      WB_WAIT,
      RD_SEND,
      DRAIN,
      STATUS
   } state_t;

   state_t         state_q;
   logic           outOfReset_q;
   logic           isWrite_q;
   logic           fixed_q;
   logic           cyc_q;
   logic           txAvail_q;
   logic           cmdErr_q;
   logic [3:0]     len_q;
   logic [3:0]     byteCnt_q;
   logic [4:0]     wordCnt_q;
   logic [DLW-1:0] dataLeft_q;
   logic [AW-1:0]  adr_q;
   logic [AW-1:0]  adr_d;
   logic [DW-1:0]  data_q;
   logic [DW-1:0]  data_d;
   logic [7:0]     txData_q;
   logic [1:0]     status_q;
`ifdef UART_WBM_TIMEOUT_EN
   logic [31:0]    toCnt_q;
`endif

   logic take;
   logic lastAdrByte;
   logic lastDataByte;
   logic lastWord;
   logic lastReadWord;

   assign take         = rx_wr & rx_ready;
   assign lastAdrByte  = (byteCnt_q == 4'(NA - 1));
   assign lastDataByte = (byteCnt_q == 4'(NB - 1));
   assign lastWord     = (wordCnt_q == {1'b0, len_q});
   assign lastReadWord = (wordCnt_q == ({1'b0, len_q} + 5'd1));

   // Shift the incoming byte into the low end of the address / data word
   always_comb begin
      adr_d  = (adr_q << 8) | AW'(rx_data);
      data_d = (data_q << 8) | DW'(rx_data);
   end

   // Bytes are only accepted while collecting a frame or discarding its tail;
   // DRAIN closes as soon as nothing is left so the next frame is not eaten.
   assign rx_ready = outOfReset_q &
                     ((state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA) ||
                      ((state_q == DRAIN) && (dataLeft_q != '0)));

   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_adr_o     = adr_q;
   assign wbm_we_o      = cyc_q & isWrite_q;
   assign wbm_dat_o     = data_q;
   assign wbm_sel_o     = {NB{cyc_q}};
   assign tx_data_avail = txAvail_q;
   assign tx_data       = txData_q;
   assign busy          = (state_q != IDLE);
   assign cmd_err       = cmdErr_q;

   // Frame sequencer: parses the byte stream, runs bus cycles and emits replies
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         outOfReset_q <= 1'b0;
         isWrite_q    <= 1'b0;
         fixed_q      <= 1'b0;
         cyc_q        <= 1'b0;
         txAvail_q    <= 1'b0;
         cmdErr_q     <= 1'b0;
         len_q        <= '0;
         byteCnt_q    <= '0;
         wordCnt_q    <= '0;
         dataLeft_q   <= '0;
         adr_q        <= '0;
         data_q       <= '0;
         txData_q     <= '0;
         status_q     <= ST_OK;
`ifdef UART_WBM_TIMEOUT_EN
         toCnt_q      <= '0;
`endif
      end else begin
         outOfReset_q <= 1'b1;
         cmdErr_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (take) begin
                  if (rx_data[5:4] != 2'b00) begin
                     cmdErr_q <= 1'b1;
                  end else begin
                     isWrite_q  <= rx_data[7];
                     fixed_q    <= rx_data[6];
                     len_q      <= rx_data[3:0];
                     byteCnt_q  <= '0;
                     wordCnt_q  <= '0;
                     dataLeft_q <= DLW'((int'(rx_data[3:0]) + 1) * NB);
                     adr_q      <= '0;
                     status_q   <= ST_OK;
                     state_q    <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (take) begin
                  adr_q     <= adr_d;
                  byteCnt_q <= byteCnt_q + 4'd1;
                  if (lastAdrByte) begin
                     byteCnt_q <= '0;
                     state_q   <= isWrite_q ? WDATA : WB_REQ;
                  end
               end
            end
            WDATA: begin
               if (take) begin
                  data_q     <= data_d;
                  dataLeft_q <= dataLeft_q - DLW'(1);
                  byteCnt_q  <= byteCnt_q + 4'd1;
                  if (lastDataByte) begin
                     byteCnt_q <= '0;
                     state_q   <= WB_REQ;
                  end
               end
            end
            WB_REQ: begin
               cyc_q   <= 1'b1;
`ifdef UART_WBM_TIMEOUT_EN
               toCnt_q <= '0;
`endif
               state_q <= WB_WAIT;
            end
            WB_WAIT: begin
               if (wbm_err_i) begin
                  cyc_q    <= 1'b0;
                  status_q <= ST_BUS_ERR;
                  state_q  <= isWrite_q ? DRAIN : STATUS;
               end else if (wbm_ack_i) begin
                  cyc_q     <= 1'b0;
                  wordCnt_q <= wordCnt_q + 5'd1;
                  if (!fixed_q) begin
                     adr_q <= adr_q + AW'(NB);
                  end
                  if (isWrite_q) begin
                     state_q <= lastWord ? STATUS : WDATA;
                  end else begin
                     data_q  <= wbm_dat_i;
                     state_q <= RD_SEND;
                  end
               end
`ifdef UART_WBM_TIMEOUT_EN
               else if (toCnt_q == 32'(TIMEOUT_CYC - 1)) begin
                  cyc_q    <= 1'b0;
                  status_q <= 2'd2;
                  state_q  <= isWrite_q ? DRAIN : STATUS;
               end else begin
                  toCnt_q <= toCnt_q + 32'd1;
               end
`endif
            end
            RD_SEND: begin
               if (!txAvail_q) begin
                  txData_q  <= data_q[DW-1 -: 8];
                  data_q    <= data_q << 8;
                  txAvail_q <= 1'b1;
               end else if (tx_rd) begin
                  txAvail_q <= 1'b0;
                  byteCnt_q <= byteCnt_q + 4'd1;
                  if (lastDataByte) begin
                     byteCnt_q <= '0;
                     state_q   <= lastReadWord ? STATUS : WB_REQ;
                  end
               end
            end
            DRAIN: begin
               if (dataLeft_q == '0) begin
                  state_q <= STATUS;
               end else if (take) begin
                  dataLeft_q <= dataLeft_q - DLW'(1);
               end
            end
            STATUS: begin
               if (!txAvail_q) begin
                  txData_q  <= {6'b100000, status_q};
                  txAvail_q <= 1'b1;
               end else if (tx_rd) begin
                  txAvail_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_wbm_burst.sv
// tb_uart_wbm_burst: directed bench for uart_wbm_burst with a small
// Wishbone slave that logs every bus cycle and answers reads with
// 0xC0DE0000 | adr[15:0]. Timeout checks follow UART_WBM_TIMEOUT_EN.
module tb_uart_wbm_burst;

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic        rx_wr;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_data_avail;
   logic [7:0]  tx_data;
   logic        tx_rd;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [31:0] wbm_adr_o;
   logic        wbm_we_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;
   logic        busy;
   logic        cmd_err;

   int checks = 0;
   int errors = 0;

   int          busCnt;
   int          errIdx;
   bit          noAck;
   logic [31:0] logAdr [16];
   logic [31:0] logDat [16];
   logic [3:0]  logSel [16];
   logic        logWe  [16];
   logic [31:0] words  [16];

   uart_wbm_burst #(
      .AW(32),
      .DW(32),
      .TIMEOUT_CYC(255)
   ) dut (
      .sys_clk(sys_clk),
      .reset_n(reset_n),
      .rx_wr(rx_wr),
      .rx_data(rx_data),
      .rx_ready(rx_ready),
      .tx_data_avail(tx_data_avail),
      .tx_data(tx_data),
      .tx_rd(tx_rd),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_we_o(wbm_we_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i),
      .busy(busy),
      .cmd_err(cmd_err)
   );

   // 100 MHz clock
   always #5 sys_clk = ~sys_clk;

   // Wishbone slave: acks each strobe one cycle later, logs it, optional err
   initial begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = '0;
      forever begin
         @(posedge sys_clk);
         #2;
         wbm_ack_i = 1'b0;
         wbm_err_i = 1'b0;
         if (wbm_cyc_o && wbm_stb_o && !noAck) begin
            if (busCnt < 16) begin
               logAdr[busCnt] = wbm_adr_o;
               logDat[busCnt] = wbm_dat_o;
               logSel[busCnt] = wbm_sel_o;
               logWe[busCnt]  = wbm_we_o;
            end
            wbm_dat_i = 32'hC0DE0000 | {16'h0000, wbm_adr_o[15:0]};
            wbm_ack_i = 1'b1;
            wbm_err_i = (busCnt == errIdx);
            busCnt++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      int t = 0;
      rx_data = b;
      rx_wr   = 1'b1;
      while (!rx_ready && t < 1000) begin
         tick();
         t++;
      end
      checkOutput($sformatf("rx_ready for byte %02h", b), rx_ready, 1'b1);
      tick();
      rx_wr = 1'b0;
   endtask

   task automatic recvByte(output logic [7:0] b);
      int t = 0;
      while (!tx_data_avail && t < 2000) begin
         tick();
         t++;
      end
      b = tx_data_avail ? tx_data : 8'hxx;
      tx_rd = 1'b1;
      tick();
      tx_rd = 1'b0;
   endtask

   task automatic sendHeader(input logic [7:0] cmd, input logic [31:0] adr);
      applyStimulus(cmd);
      for (int k = 3; k >= 0; k--) applyStimulus(adr[8*k +: 8]);
   endtask

   task automatic writeFrame(input logic [7:0] cmd, input logic [31:0] adr, input int n);
      sendHeader(cmd, adr);
      for (int i = 0; i < n; i++)
         for (int k = 3; k >= 0; k--) applyStimulus(words[i][8*k +: 8]);
   endtask

   task automatic checkReadBytes(input string tag, input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++)
         for (int k = 3; k >= 0; k--) begin
            recvByte(b);
            checkOutput($sformatf("%s w%0d b%0d", tag, i, k), b, words[i][8*k +: 8]);
         end
   endtask

   task automatic checkStatus(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      recvByte(b);
      checkOutput(tag, b, exp);
   endtask

   task automatic waitCyc(input string tag);
      int t = 0;
      while (!wbm_cyc_o && t < 200) begin
         tick();
         t++;
      end
      checkOutput(tag, wbm_cyc_o, 1'b1);
   endtask

   // Directed sequence covering every required scenario in order
   initial begin
      logic [7:0] b;
      int         cnt;
      int         bad;
      int         seen;

      rx_wr   = 1'b0;
      rx_data = '0;
      tx_rd   = 1'b0;
      noAck   = 1'b0;
      errIdx  = -1;
      busCnt  = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("reset outputs",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, cmd_err,
                   tx_data_avail, rx_ready, tx_data}, 19'h0);
      checkOutput("reset adr", wbm_adr_o, 32'h0);
      checkOutput("reset dat", wbm_dat_o, 32'h0);
      reset_n = 1'b1;
      tick();
      checkOutput("ready after reset", rx_ready, 1'b1);

      $display("[TB] single write");
      busCnt   = 0;
      words[0] = 32'hDEADBEEF;
      writeFrame(8'h80, 32'h10000004, 1);
      checkStatus("single write status", 8'h80);
      checkOutput("single write count", busCnt, 1);
      checkOutput("single write adr", logAdr[0], 32'h10000004);
      checkOutput("single write dat", logDat[0], 32'hDEADBEEF);
      checkOutput("single write sel", logSel[0], 4'hF);
      checkOutput("single write we", logWe[0], 1'b1);
      checkOutput("idle after frame", busy, 1'b0);

      $display("[TB] incrementing read burst");
      busCnt   = 0;
      words[0] = 32'hC0DE0100;
      words[1] = 32'hC0DE0104;
      words[2] = 32'hC0DE0108;
      words[3] = 32'hC0DE010C;
      sendHeader(8'h03, 32'h00000100);
      checkReadBytes("read burst", 4);
      checkStatus("read burst status", 8'h80);
      checkOutput("read burst count", busCnt, 4);
      checkOutput("read adr 0", logAdr[0], 32'h00000100);
      checkOutput("read adr 1", logAdr[1], 32'h00000104);
      checkOutput("read adr 2", logAdr[2], 32'h00000108);
      checkOutput("read adr 3", logAdr[3], 32'h0000010C);
      checkOutput("read we", logWe[0], 1'b0);

      $display("[TB] fixed-address write");
      busCnt   = 0;
      words[0] = 32'h01234567;
      words[1] = 32'h89ABCDEF;
      writeFrame(8'hC1, 32'h20000000, 2);
      checkStatus("fixed write status", 8'h80);
      checkOutput("fixed write count", busCnt, 2);
      checkOutput("fixed adr 0", logAdr[0], 32'h20000000);
      checkOutput("fixed adr 1", logAdr[1], 32'h20000000);
      checkOutput("fixed dat 0", logDat[0], 32'h01234567);
      checkOutput("fixed dat 1", logDat[1], 32'h89ABCDEF);

      $display("[TB] bus error mid-burst");
      busCnt   = 0;
      errIdx   = 1;
      words[0] = 32'h11111111;
      words[1] = 32'h22222222;
      words[2] = 32'h33333333;
      words[3] = 32'h44444444;
      writeFrame(8'h83, 32'h40000000, 4);
      checkStatus("error status", 8'h81);
      checkOutput("error bus count", busCnt, 2);
      checkOutput("error dat 1", logDat[1], 32'h22222222);
      errIdx   = -1;
      busCnt   = 0;
      words[0] = 32'hCAFEF00D;
      writeFrame(8'h80, 32'h30000000, 1);
      checkStatus("after error status", 8'h80);
      checkOutput("after error count", busCnt, 1);
      checkOutput("after error adr", logAdr[0], 32'h30000000);
      checkOutput("after error dat", logDat[0], 32'hCAFEF00D);

      $display("[TB] illegal command");
      applyStimulus(8'h30);
      checkOutput("cmd_err pulse", cmd_err, 1'b1);
      checkOutput("illegal stays idle", busy, 1'b0);
      tick();
      checkOutput("cmd_err one cycle", cmd_err, 1'b0);
      seen = 0;
      repeat (10) begin
         tick();
         if (tx_data_avail) seen++;
      end
      checkOutput("illegal no tx", seen, 0);

      $display("[TB] address wrap");
      busCnt   = 0;
      words[0] = 32'hC0DEFFFC;
      words[1] = 32'hC0DE0000;
      sendHeader(8'h01, 32'hFFFFFFFC);
      checkReadBytes("wrap read", 2);
      checkStatus("wrap status", 8'h80);
      checkOutput("wrap adr 0", logAdr[0], 32'hFFFFFFFC);
      checkOutput("wrap adr 1", logAdr[1], 32'h00000000);

      $display("[TB] tx flow control");
      words[0] = 32'hC0DE0200;
      sendHeader(8'h00, 32'h00000200);
      cnt = 0;
      while (!tx_data_avail && cnt < 200) begin
         tick();
         cnt++;
      end
      checkOutput("flow first byte", tx_data, 8'hC0);
      bad = 0;
      repeat (50) begin
         tick();
         if (tx_data !== 8'hC0 || tx_data_avail !== 1'b1) bad++;
      end
      checkOutput("flow hold 50", bad, 0);
      recvByte(b);
      checkOutput("flow byte 0", b, 8'hC0);
      checkOutput("flow gap after rd", tx_data_avail, 1'b0);
      recvByte(b);
      checkOutput("flow byte 1", b, 8'hDE);
      recvByte(b);
      checkOutput("flow byte 2", b, 8'h02);
      recvByte(b);
      checkOutput("flow byte 3", b, 8'h00);
      checkStatus("flow status", 8'h80);

`ifdef UART_WBM_TIMEOUT_EN
      $display("[TB] read timeout");
      noAck = 1'b1;
      sendHeader(8'h00, 32'h00000040);
      waitCyc("timeout cyc rise");
      cnt = 0;
      while (wbm_stb_o && cnt < 1000) begin
         tick();
         cnt++;
      end
      checkOutput("timeout stb cycles", cnt, 255);
      checkStatus("timeout status", 8'h82);
      noAck = 1'b0;
`else
      $display("[TB] indefinite wait");
      noAck    = 1'b1;
      words[0] = 32'hC0DE0040;
      sendHeader(8'h00, 32'h00000040);
      waitCyc("wait cyc rise");
      bad = 0;
      repeat (300) begin
         tick();
         if (wbm_stb_o !== 1'b1 || tx_data_avail !== 1'b0) bad++;
      end
      checkOutput("wait holds stb", bad, 0);
      noAck = 1'b0;
      checkReadBytes("late ack read", 1);
      checkStatus("late ack status", 8'h80);
`endif

      $display("[TB] reset during WB_WAIT");
      noAck = 1'b1;
      sendHeader(8'h00, 32'h00000080);
      waitCyc("reset test cyc rise");
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      checkOutput("reset mid cyc", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      checkOutput("reset mid busy", busy, 1'b0);
      checkOutput("reset mid outputs", {wbm_sel_o, tx_data_avail, rx_ready, wbm_adr_o}, 38'h0);
      reset_n = 1'b1;
      noAck   = 1'b0;
      seen    = 0;
      repeat (30) begin
         tick();
         if (tx_data_avail || wbm_cyc_o) seen++;
      end
      checkOutput("no status after reset", seen, 0);
      busCnt   = 0;
      words[0] = 32'h5A5A5A5A;
      writeFrame(8'h80, 32'h00000050, 1);
      checkStatus("post reset status", 8'h80);
      checkOutput("post reset dat", logDat[0], 32'h5A5A5A5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_wbm_burst.md
UART_WBM_BURST -- requirements
Module: uart_wbm_burst

Interface
REQ-001 Parameters SHALL be: AW, default 32, Wishbone address width (multiple of 8); DW, default 32, data width (8/16/32/64); TIMEOUT_CYC, default 255, Wishbone wait limit in cycles.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset. Ports, clock and reset first:
- sys_clk  in  1  sole clock.
- reset_n  in  1  synchronous active-low reset.
- rx_wr  in  1  received byte strobe.
- rx_data  in  8  received byte.
- rx_ready  out  1  block accepts a byte this cycle.
- tx_data_avail  out  1  response byte pending.
- tx_data  out  8  response byte.
- tx_rd  in  1  response byte consumed.
- wbm_cyc_o / wbm_stb_o  out  1  bus cycle/strobe.
- wbm_adr_o  out  AW  byte address.
- wbm_we_o  out  1  write.
- wbm_dat_o  out  DW  write data.
- wbm_sel_o  out  DW/8  byte enables.
- wbm_dat_i  in  DW  read data.
- wbm_ack_i / wbm_err_i  in  1  bus ack/error.
- busy  out  1  frame in progress.
- cmd_err  out  1  one-cycle pulse on an illegal command byte.

Function
REQ-003 The frame SHALL be: CMD byte, then AW/8 address bytes MSB first, then for writes only LEN*DW/8 data bytes, with each word sent MSB first.
REQ-004 CMD SHALL decode as: bit7 1=write/0=read; bit6 1=fixed address/0=incrementing; bits[5:4] must be 00; bits[3:0]=LEN-1, so LEN is 1..16.
REQ-005 A CMD byte with bits[5:4]!=00 SHALL be dropped, pulse cmd_err for one cycle, and leave the FSM in IDLE.
REQ-006 FSM states SHALL be IDLE, ADDR, WDATA, WB_REQ, WB_WAIT, RD_SEND, DRAIN, STATUS.
REQ-007 Transitions SHALL be:
- IDLE->ADDR on a legal CMD.
- ADDR->WDATA (write) or WB_REQ (read) after the last address byte.
- WDATA->WB_REQ once a full word is assembled.
- WB_REQ->WB_WAIT.
- WB_WAIT->WDATA, RD_SEND, STATUS or DRAIN as defined below.
- RD_SEND->WB_REQ, or STATUS after the last word.
- DRAIN->STATUS.
- STATUS->IDLE on tx_rd.
REQ-008 rx_ready SHALL be high only in IDLE, ADDR, WDATA and DRAIN; a byte is taken only when rx_wr=1 and rx_ready=1.
REQ-009 wbm_cyc_o and wbm_stb_o SHALL assert together on the cycle after entry to WB_REQ and stay high until the first cycle with ack or err; wbm_sel_o SHALL be all ones while stb is high.
REQ-010 wbm_adr_o SHALL advance by DW/8 after each acked word in incrementing mode, modulo 2^AW, wrapping silently at the top; in fixed mode it SHALL hold.
REQ-011 err and ack asserted in the same cycle SHALL count as err.
REQ-012 After an acked write, the FSM SHALL go to WDATA, or to STATUS after word LEN.
REQ-013 After an acked read, wbm_dat_i SHALL be captured, then sent in RD_SEND as DW/8 bytes, MSB first.
REQ-014 tx_data_avail SHALL stay high and tx_data stable until tx_rd; the next byte SHALL be presented no earlier than the cycle after tx_rd.
REQ-015 A write error SHALL stop further bus cycles; DRAIN SHALL consume and discard the remaining frame bytes, then go to STATUS.
REQ-016 A read error SHALL skip the remaining words and go directly to STATUS.
REQ-017 The STATUS byte SHALL be 0x80 for OK, 0x81 for bus error and 0x82 for timeout; it is the final byte of every legal frame.
REQ-018 busy SHALL be high in every state except IDLE.

Reset
REQ-019 While reset_n=0 at a sys_clk edge, the FSM SHALL go to IDLE and all counters, address and data registers SHALL clear.
REQ-020 During reset, all outputs SHALL be 0 except wbm_sel_o, which is also 0.
REQ-021 A reset mid-frame SHALL drop cyc/stb at that edge and discard the partial frame; no STATUS byte is sent.

Configuration
REQ-022 With UART_WBM_TIMEOUT_EN defined, a counter SHALL run in WB_WAIT. After TIMEOUT_CYC cycles without ack or err:
- cyc/stb deassert.
- Reads go to STATUS; writes go to DRAIN.
- The status byte is 0x82.
- An ack or err on the expiry cycle wins over the timeout.
REQ-023 Without UART_WBM_TIMEOUT_EN, WB_WAIT SHALL wait indefinitely, TIMEOUT_CYC SHALL be ignored, and 0x82 SHALL never be produced.

Verification
REQ-024 Write, LEN 1: bytes 0x80,0x10,0x00,0x00,0x04,0xDE,0xAD,0xBE,0xEF -> one write, adr 0x10000004, dat 0xDEADBEEF, sel 0xF; tx 0x80.
REQ-025 Read burst, incrementing: 0x03, address 0x00000100, ack each word -> addresses 0x100, 0x104, 0x108, 0x10C; 16 data bytes, then 0x80.
REQ-026 Fixed-address write: 0xC1, address 0x20000000, 8 data bytes -> two writes, both to 0x20000000; tx 0x80.
REQ-027 Error mid-burst: write LEN 4 with err (plus ack) on word 2 -> exactly 2 bus cycles; remaining 8 bytes drained; tx 0x81; next frame is handled normally.
REQ-028 Illegal command and timeout:
- CMD 0x30 -> cmd_err one-cycle pulse; FSM stays IDLE; no tx.
- With UART_WBM_TIMEOUT_EN, read with no ack -> stb drops after 255 cycles; tx 0x82.
REQ-029 Reset and flow control:
- reset_n=0 during WB_WAIT -> cyc=0 at next edge; busy=0; no status byte.
- tx_rd held off 50 cycles -> tx_data stays stable for all 50 cycles.
